// File: rtl/encoder_pkg.sv
// Shared encoding constants: instruction kinds, base opcodes, the canonical NOP
// and the encoder FSM state type.
package encoder_pkg;

    localparam logic [2:0] KIND_R      = 3'd0;
    localparam logic [2:0] KIND_IARITH = 3'd1;
    localparam logic [2:0] KIND_LOAD   = 3'd2;
    localparam logic [2:0] KIND_STORE  = 3'd3;
    localparam logic [2:0] KIND_BRANCH = 3'd4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_PAD
    } encState_e;

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational field packer: instruction kind plus fields -> 32-bit RV32I word.
// Kinds outside the supported set raise illegal and produce a zero word.
module inst_pack
    import encoder_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [12:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    // Branch offsets are always even, so bit 0 carries no information.
    logic unusedImmLsb;
    assign unusedImmLsb = imm[0];

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (kind)
            KIND_R:      word = {funct7, rs2, rs1, funct3, rd, OP_R};
            KIND_IARITH: word = {imm[11:0], rs1, funct3, rd, OP_IARITH};
            KIND_LOAD:   word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
            KIND_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
            KIND_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
            default:     illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: accepts encode requests or NOP-pad requests and writes the
// resulting words sequentially into instruction memory, one word per cycle.
module inst_encoder
    import encoder_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE      = 32'h0000_0000,
    parameter int          PAD_WORDS = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [2:0]               kind_i,
    input  logic [2:0]               funct3_i,
    input  logic [6:0]               funct7_i,
    input  logic [4:0]               rd_i,
    input  logic [4:0]               rs1_i,
    input  logic [4:0]               rs2_i,
    input  logic [12:0]              imm_i,
    input  logic                     pad_i,
    output logic                     mem_we_o,
    output logic [31:0]              mem_addr_o,
    output logic [31:0]              mem_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     err_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(PAD_WORDS + 1);

    encState_e       stateReg;
    logic [CW-1:0]   countReg;
    logic [PW-1:0]   padLeftReg;
    logic            weReg;
    logic [31:0]     addrReg;
    logic [31:0]     dataReg;
    logic            errReg;

    logic [31:0]     packedWord;
    logic            packedIllegal;
    logic [CW-1:0]   countInc;

    inst_pack packer (
        .kind    (kind_i),
        .funct3  (funct3_i),
        .funct7  (funct7_i),
        .rd      (rd_i),
        .rs1     (rs1_i),
        .rs2     (rs2_i),
        .imm     (imm_i),
        .word    (packedWord),
        .illegal (packedIllegal)
    );

    function automatic logic [31:0] addrAt(input logic [CW-1:0] c);
        return BASE + (32'(c) << 2);
    endfunction

    assign countInc    = countReg + CW'(1);
    assign full_o      = (countReg == CW'(DEPTH));
    assign req_ready_o = (stateReg == ST_IDLE) && !full_o && !pad_i;

    // A write registered just before reset must not reach memory in the reset cycle.
    assign mem_we_o   = weReg && !rst_i;
    assign mem_addr_o = mem_we_o ? addrReg : '0;
    assign mem_data_o = mem_we_o ? dataReg : '0;
    assign count_o    = countReg;
    assign err_o      = errReg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stateReg   <= ST_IDLE;
            countReg   <= '0;
            padLeftReg <= '0;
            weReg      <= 1'b0;
            addrReg    <= '0;
            dataReg    <= '0;
            errReg     <= 1'b0;
        end else begin
            case (stateReg)
                ST_IDLE: begin
                    if (pad_i && !full_o) begin
                        stateReg   <= ST_PAD;
                        weReg      <= 1'b1;
                        addrReg    <= addrAt(countReg);
                        dataReg    <= NOP_WORD;
                        padLeftReg <= PW'(PAD_WORDS - 1);
                    end else if (req_valid_i && req_ready_o) begin
                        if (packedIllegal) begin
                            errReg <= 1'b1;
                        end else begin
                            stateReg <= ST_WRITE;
                            weReg    <= 1'b1;
                            addrReg  <= addrAt(countReg);
                            dataReg  <= packedWord;
                        end
                    end
                end
                ST_WRITE: begin
                    countReg <= countInc;
                    stateReg <= ST_IDLE;
                    weReg    <= 1'b0;
                    addrReg  <= '0;
                    dataReg  <= '0;
                end
                ST_PAD: begin
                    countReg <= countInc;
                    // Stop early when the memory fills so the count never exceeds DEPTH.
                    if (padLeftReg != '0 && countInc != CW'(DEPTH)) begin
                        addrReg    <= addrAt(countInc);
                        padLeftReg <= padLeftReg - PW'(1);
                    end else begin
                        stateReg <= ST_IDLE;
                        weReg    <= 1'b0;
                        addrReg  <= '0;
                        dataReg  <= '0;
                    end
                end
                default: stateReg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: fixed vectors, multi-cycle corner cases
// and randomized traffic against a transaction-level reference model.
module tb_inst_encoder;

    localparam int          DEPTH     = 256;
    localparam int          PAD_WORDS = 4;
    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam int          CW        = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic          clk_i;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [2:0]    kind_i;
    logic [2:0]    funct3_i;
    logic [6:0]    funct7_i;
    logic [4:0]    rd_i;
    logic [4:0]    rs1_i;
    logic [4:0]    rs2_i;
    logic [12:0]   imm_i;
    logic          pad_i;
    logic          mem_we_o;
    logic [31:0]   mem_addr_o;
    logic [31:0]   mem_data_o;
    logic [CW-1:0] count_o;
    logic          full_o;
    logic          err_o;

    inst_encoder #(.DEPTH(DEPTH), .BASE(BASE), .PAD_WORDS(PAD_WORDS)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .kind_i      (kind_i),
        .funct3_i    (funct3_i),
        .funct7_i    (funct7_i),
        .rd_i        (rd_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .imm_i       (imm_i),
        .pad_i       (pad_i),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .count_o     (count_o),
        .full_o      (full_o),
        .err_o       (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int mCount = 0;
    bit mErr   = 1'b0;

    typedef struct {
        logic [2:0]  kind;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [12:0] imm;
        logic [31:0] expData;
        bit          legal;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Reference encoding built from bit weights of each field.
    function automatic logic [32:0] refEncode(input int unsigned k, input int unsigned f3,
                                              input int unsigned f7, input int unsigned rd,
                                              input int unsigned rs1, input int unsigned rs2,
                                              input int unsigned imm);
        int unsigned w;
        int unsigned common;
        common = (rs1 << 15) | (f3 << 12);
        case (k)
            0: w = (f7 << 25) | (rs2 << 20) | common | (rd << 7) | 32'h33;
            1: w = ((imm & 32'hFFF) << 20) | common | (rd << 7) | 32'h13;
            2: w = ((imm & 32'hFFF) << 20) | common | (rd << 7) | 32'h03;
            3: w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | common
                   | ((imm & 32'h1F) << 7) | 32'h23;
            4: w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                   | common | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
            default: return 33'd0;
        endcase
        return {1'b1, w};
    endfunction

    task automatic checkQuiet(input string tag);
        check({tag, ".we"},    32'(mem_we_o),   32'd0);
        check({tag, ".addr"},  mem_addr_o,      32'd0);
        check({tag, ".data"},  mem_data_o,      32'd0);
        check({tag, ".count"}, 32'(count_o),    32'(mCount));
        check({tag, ".full"},  32'(full_o),     32'(mCount == DEPTH));
        check({tag, ".err"},   32'(err_o),      32'(mErr));
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle.
    task automatic doReq(input logic [2:0] k, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [12:0] imm, input logic [31:0] expData, input bit legal,
                         input string tag);
        bit acc;
        kind_i = k; funct3_i = f3; funct7_i = f7;
        rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
        req_valid_i = 1'b1;
        #1;
        acc = (mCount != DEPTH);
        check({tag, ".ready"}, 32'(req_ready_o), 32'(acc));
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        if (acc && legal) begin
            check({tag, ".we"},    32'(mem_we_o), 32'd1);
            check({tag, ".addr"},  mem_addr_o,    BASE + 32'(4 * mCount));
            check({tag, ".data"},  mem_data_o,    expData);
            check({tag, ".cpre"},  32'(count_o),  32'(mCount));
            @(posedge clk_i); #1;
            mCount++;
        end else if (acc) begin
            mErr = 1'b1;
        end
        checkQuiet({tag, ".post"});
        $display("req %s kind=%0d data=%h count=%0d err=%0d", tag, k, expData, mCount, mErr);
    endtask

    task automatic doRandReq(input string tag);
        logic [2:0] k; logic [2:0] f3; logic [6:0] f7;
        logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2; logic [12:0] imm;
        logic [32:0] r;
        k = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        f3 = 3'($urandom); f7 = 7'($urandom); rd = 5'($urandom);
        rs1 = 5'($urandom); rs2 = 5'($urandom); imm = 13'($urandom);
        r = refEncode(k, f3, f7, rd, rs1, rs2, imm);
        doReq(k, f3, f7, rd, rs1, rs2, imm, r[31:0], r[32], tag);
    endtask

    task automatic doPad(input bit withReq, input string tag);
        int n;
        pad_i = 1'b1;
        if (withReq) begin
            req_valid_i = 1'b1; kind_i = 3'd1; funct3_i = 3'($urandom);
            rd_i = 5'($urandom); rs1_i = 5'($urandom); imm_i = 13'($urandom);
        end
        #1;
        check({tag, ".ready"}, 32'(req_ready_o), 32'd0);
        n = (DEPTH - mCount < PAD_WORDS) ? DEPTH - mCount : PAD_WORDS;
        @(posedge clk_i); #1;
        pad_i = 1'b0;
        req_valid_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            check({tag, ".we"},   32'(mem_we_o), 32'd1);
            check({tag, ".addr"}, mem_addr_o,    BASE + 32'(4 * mCount));
            check({tag, ".data"}, mem_data_o,    NOP);
            @(posedge clk_i); #1;
            mCount++;
        end
        checkQuiet({tag, ".post"});
        $display("pad %s words=%0d count=%0d", tag, n, mCount);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; req_valid_i = 1'b0; pad_i = 1'b0;
        kind_i = '0; funct3_i = '0; funct7_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0; imm_i = '0;

        vecs[0] = '{3'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 13'd0,      32'h002081B3, 1'b1};
        vecs[1] = '{3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'd5,      32'h00500093, 1'b1};
        vecs[2] = '{3'd3, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 13'd8,      32'h0020A423, 1'b1};
        vecs[3] = '{3'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 13'h1FF8,   32'hFE208CE3, 1'b1};
        vecs[4] = '{3'd2, 3'd2, 7'd0, 5'd5, 5'd2, 5'd0, 13'h010,    32'h01012283, 1'b1};
        vecs[5] = '{3'd5, 3'd1, 7'd9, 5'd7, 5'd7, 5'd7, 13'h0AA,    32'h00000000, 1'b0};

        repeat (2) @(posedge clk_i);
        #1;
        checkQuiet("reset");
        rst_i = 1'b0;
        $display("reset released");

        for (int i = 0; i < 6; i++) begin
            doReq(vecs[i].kind, vecs[i].f3, vecs[i].f7, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].imm, vecs[i].expData, vecs[i].legal, $sformatf("vec%0d", i));
        end

        // pad_i raised while a write is in flight must be dropped, not queued
        kind_i = 3'd1; funct3_i = 3'd0; rd_i = 5'd2; rs1_i = 5'd2; imm_i = 13'd1;
        req_valid_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        pad_i = 1'b1;
        check("padInWrite.we", 32'(mem_we_o), 32'd1);
        check("padInWrite.data", mem_data_o, 32'h00110113);
        @(posedge clk_i); #1;
        pad_i = 1'b0;
        mCount++;
        checkQuiet("padInWrite.t2");
        @(posedge clk_i); #1;
        checkQuiet("padInWrite.t3");
        $display("pad during write ignored count=%0d", mCount);

        doPad(1'b1, "padWithReq");

        for (int i = 0; i < 40; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
                doRandReq($sformatf("rnd%0d", i));
            end else if (r < 8) begin
                doPad(1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
            end else begin
                @(posedge clk_i); #1;
                checkQuiet($sformatf("rnd%0d.idle", i));
                $display("idle rnd%0d", i);
            end
        end

        // Reset in the middle of a pad burst
        pad_i = 1'b1;
        @(posedge clk_i); #1;
        pad_i = 1'b0;
        check("rstPad.we1", 32'(mem_we_o), 32'd1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        #1;
        check("rstPad.we",   32'(mem_we_o), 32'd0);
        check("rstPad.addr", mem_addr_o,    32'd0);
        check("rstPad.data", mem_data_o,    32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        mCount = 0;
        mErr = 1'b0;
        checkQuiet("rstPad.after");
        @(posedge clk_i); #1;
        checkQuiet("rstPad.idle");
        $display("reset during pad count=%0d", mCount);

        while (mCount < DEPTH - 2) begin
            if (DEPTH - 2 - mCount >= PAD_WORDS) doPad(1'b0, "fill");
            else doRandReq("fillReq");
        end

        doPad(1'b0, "padToFull");
        check("full.count", 32'(count_o), 32'(DEPTH));
        check("full.flag",  32'(full_o),  32'd1);
        check("full.ready", 32'(req_ready_o), 32'd0);
        doReq(3'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 13'd0, 32'h002081B3, 1'b1, "reqWhenFull");
        doPad(1'b0, "padWhenFull");
        repeat (3) begin
            @(posedge clk_i); #1;
            checkQuiet("fullIdle");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
